// File: rtl/cnn_dense_pkg.sv
// -----------------------------------------------------------------------------
// cnn_dense_pkg
//   Shared defaults and FSM encoding for the fully-connected classifier stage.
//   Imported by cnn_dense (top) and cnn_dense_mac (datapath).
// -----------------------------------------------------------------------------
package cnn_dense_pkg;

   localparam int DATA_SIZE_DEF = 16;  // signed fixed-point word width
   localparam int MEM_SIZE_DEF  = 16;  // memory address width
   localparam int FRAC_DEF      = 8;   // fractional bits of the Q format
   localparam int ACC_SIZE_DEF  = 40;  // accumulator width, >= 2*DATA_SIZE+8

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BIAS  = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_WR    = 3'd4,
      S_DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/cnn_dense_mac.sv
// -----------------------------------------------------------------------------
// cnn_dense_mac
//   Signed multiply-accumulate register for one dot product.
//   clr    : zero the accumulator
//   load   : acc <= sext(b_in) <<< FRAC (bias aligned to product scale)
//   acc_en : acc <= acc + x_in*w_in (full-precision signed product)
//   acc    : registered accumulator, ACC_SIZE wide, wraps silently
// Ports: clk, rst (async active-low), clr, load, acc_en, b_in, x_in, w_in, acc.
// -----------------------------------------------------------------------------
module cnn_dense_mac
   import cnn_dense_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int FRAC      = FRAC_DEF,
   parameter int ACC_SIZE  = ACC_SIZE_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       load,
   input  logic                       acc_en,
   input  logic signed [DATA_SIZE-1:0] b_in,
   input  logic signed [DATA_SIZE-1:0] x_in,
   input  logic signed [DATA_SIZE-1:0] w_in,
   output logic signed [ACC_SIZE-1:0]  acc
);

   logic signed [2*DATA_SIZE-1:0] prod;
   logic signed [ACC_SIZE-1:0]    acc_d, acc_q;

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      prod  = x_in * w_in;
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (load) begin
         acc_d = {{(ACC_SIZE-DATA_SIZE){b_in[DATA_SIZE-1]}}, b_in} <<< FRAC;
      end else if (acc_en) begin
         acc_d = acc_q + {{(ACC_SIZE-2*DATA_SIZE){prod[2*DATA_SIZE-1]}}, prod};
      end
   end

   // NOTE: state registers use non-blocking assignment only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) acc_q <= '0;
      else      acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/cnn_dense.sv
// -----------------------------------------------------------------------------
// cnn_dense
//   Fully-connected classifier stage. On en it latches NI/NO and computes NO
//   dot products of length NI: y[j] = sat((b[j]<<<FRAC + sum x[i]*w[j*NI+i]) >>> FRAC).
//   Results go to the result memory through y_we/y_wa/y_wd.
// Ports:
//   clk, rst (async active-low), en (start/hold level), NI, NO (sampled at start)
//   x_rd/w_rd/b_rd : read data, valid one cycle after the matching address
//   done           : job complete, held while en stays high
//   x_ra/w_ra/b_ra : feature / weight (row-major) / bias read addresses
//   y_we/y_wa/y_wd : result write port
//   cls            : argmax class index
// Configuration:
//   CNN_DENSE_ARGMAX_EN defined   -> cls tracks the first index of the largest y.
//   CNN_DENSE_ARGMAX_EN undefined -> no comparator, cls tied to 0.
// -----------------------------------------------------------------------------
module cnn_dense
   import cnn_dense_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int MEM_SIZE  = MEM_SIZE_DEF,
   parameter int FRAC      = FRAC_DEF,
   parameter int ACC_SIZE  = ACC_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [DATA_SIZE-1:0] NI,
   input  logic [DATA_SIZE-1:0] NO,
   input  logic [DATA_SIZE-1:0] x_rd,
   input  logic [DATA_SIZE-1:0] w_rd,
   input  logic [DATA_SIZE-1:0] b_rd,
   output logic                 done,
   output logic [MEM_SIZE-1:0]  x_ra,
   output logic [MEM_SIZE-1:0]  w_ra,
   output logic [MEM_SIZE-1:0]  b_ra,
   output logic                 y_we,
   output logic [MEM_SIZE-1:0]  y_wa,
   output logic [DATA_SIZE-1:0] y_wd,
   output logic [DATA_SIZE-1:0] cls
);

   state_e                      state_d, state_q;
   logic [DATA_SIZE-1:0]        ni_d, ni_q, no_d, no_q;
   logic [DATA_SIZE-1:0]        i_d, i_q, j_d, j_q;
   logic [MEM_SIZE-1:0]         wbase_d, wbase_q;
   logic                        mac_clr, mac_load, mac_acc;
   logic signed [ACC_SIZE-1:0]  acc, acc_sh;
   logic signed [DATA_SIZE-1:0] y_sat;
   logic                        job_active;

   cnn_dense_mac #(
      .DATA_SIZE (DATA_SIZE),
      .FRAC      (FRAC),
      .ACC_SIZE  (ACC_SIZE)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (mac_clr),
      .load   (mac_load),
      .acc_en (mac_acc),
      .b_in   (b_rd),
      .x_in   (x_rd),
      .w_in   (w_rd),
      .acc    (acc)
   );

   assign job_active = (state_q == S_BIAS) || (state_q == S_MAC) ||
                       (state_q == S_DRAIN) || (state_q == S_WR);

   always_comb begin
      state_d  = state_q;
      ni_d     = ni_q;
      no_d     = no_q;
      i_d      = i_q;
      j_d      = j_q;
      wbase_d  = wbase_q;
      mac_clr  = 1'b0;
      mac_load = 1'b0;
      mac_acc  = 1'b0;
      if (job_active && !en) begin
         // Abort: counters freeze, results already written stay in memory.
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (en) begin
                  ni_d    = NI;
                  no_d    = NO;
                  i_d     = '0;
                  j_d     = '0;
                  wbase_d = '0;
                  mac_clr = 1'b1;
                  state_d = (NI == '0 || NO == '0) ? S_DONE : S_BIAS;
               end
            end
            S_BIAS: begin
               i_d     = '0;
               state_d = S_MAC;
            end
            S_MAC: begin
               // Read data lags the address by one cycle: the first MAC cycle
               // sees the bias, later cycles see the product for i-1.
               if (i_q == '0) mac_load = 1'b1;
               else           mac_acc  = 1'b1;
               if (i_q == ni_q - DATA_SIZE'(1)) state_d = S_DRAIN;
               else                            i_d     = i_q + DATA_SIZE'(1);
            end
            S_DRAIN: begin
               mac_acc = 1'b1;
               state_d = S_WR;
            end
            S_WR: begin
               if (j_q == no_q - DATA_SIZE'(1)) begin
                  state_d = S_DONE;
               end else begin
                  j_d     = j_q + DATA_SIZE'(1);
                  wbase_d = wbase_q + MEM_SIZE'(ni_q);
                  state_d = S_BIAS;
               end
            end
            S_DONE: begin
               if (!en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ni_q    <= '0;
         no_q    <= '0;
         i_q     <= '0;
         j_q     <= '0;
         wbase_q <= '0;
      end else begin
         state_q <= state_d;
         ni_q    <= ni_d;
         no_q    <= no_d;
         i_q     <= i_d;
         j_q     <= j_d;
         wbase_q <= wbase_d;
      end
   end

   // Floor rescale, then clamp when the dropped upper bits are not a pure
   // sign extension of the kept word.
   always_comb begin
      acc_sh = acc >>> FRAC;
      if (&acc_sh[ACC_SIZE-1:DATA_SIZE-1] || ~|acc_sh[ACC_SIZE-1:DATA_SIZE-1])
         y_sat = acc_sh[DATA_SIZE-1:0];
      else if (acc_sh[ACC_SIZE-1])
         y_sat = {1'b1, {(DATA_SIZE-1){1'b0}}};
      else
         y_sat = {1'b0, {(DATA_SIZE-1){1'b1}}};
   end

   assign done = (state_q == S_DONE);
   assign y_we = (state_q == S_WR) && en;
   assign x_ra = MEM_SIZE'(i_q);
   assign w_ra = wbase_q + MEM_SIZE'(i_q);
   assign b_ra = MEM_SIZE'(j_q);
   assign y_wa = MEM_SIZE'(j_q);
   assign y_wd = y_sat;

`ifdef CNN_DENSE_ARGMAX_EN
   logic signed [DATA_SIZE-1:0] best_d, best_q;
   logic [DATA_SIZE-1:0]        cls_d, cls_q;

   always_comb begin
      best_d = best_q;
      cls_d  = cls_q;
      if (state_q == S_IDLE && en) begin
         best_d = '0;
         cls_d  = '0;
      end else if (y_we && (j_q == '0 || y_sat > best_q)) begin
         // Strictly greater keeps the lowest index on ties.
         best_d = y_sat;
         cls_d  = j_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         best_q <= '0;
         cls_q  <= '0;
      end else begin
         best_q <= best_d;
         cls_q  <= cls_d;
      end
   end

   assign cls = cls_q;
`else
   assign cls = '0;
`endif

endmodule

// File: tb/tb_cnn_dense.sv
// -----------------------------------------------------------------------------
// tb_cnn_dense
//   Self-checking bench for cnn_dense. Memories are modelled as arrays with a
//   one-cycle registered read; expected results come from a whole-dot-product
//   model of the Q-format arithmetic. Build with +define+CNN_DENSE_ARGMAX_EN to
//   exercise the argmax output.
// -----------------------------------------------------------------------------
module tb_cnn_dense;

   localparam int DW   = 16;
   localparam int MW   = 16;
   localparam int FRAC = 8;
   localparam int ACCW = 40;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en  = 1'b0;
   logic [DW-1:0] NI  = '0;
   logic [DW-1:0] NO  = '0;
   logic [DW-1:0] x_rd = '0, w_rd = '0, b_rd = '0;
   logic          done, y_we;
   logic [MW-1:0] x_ra, w_ra, b_ra, y_wa;
   logic [DW-1:0] y_wd, cls;

   logic [DW-1:0] xmem [256];
   logic [DW-1:0] wmem [256];
   logic [DW-1:0] bmem [256];
   logic [DW-1:0] ymem [256];

   logic [DW-1:0] exp_d [$];
   logic [MW-1:0] exp_a [$];
   int            n_cmp    = 0;
   int            n_bad    = 0;
   int            n_writes = 0;
   bit            busy     = 1'b0;

   cnn_dense u_dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .NI   (NI),
      .NO   (NO),
      .x_rd (x_rd),
      .w_rd (w_rd),
      .b_rd (b_rd),
      .done (done),
      .x_ra (x_ra),
      .w_ra (w_ra),
      .b_ra (b_ra),
      .y_we (y_we),
      .y_wa (y_wa),
      .y_wd (y_wd),
      .cls  (cls)
   );

   always #5 clk = ~clk;

   // Synchronous-read memories: data for an address appears one cycle later.
   always @(posedge clk) begin
      x_rd <= xmem[x_ra[7:0]];
      w_rd <= wmem[w_ra[7:0]];
      b_rd <= bmem[b_ra[7:0]];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: complete dot product with ACC_SIZE wrap, floor rescale, clamp.
   function automatic logic [DW-1:0] model_y(input int ni, input int j);
      longint acc, q;
      acc = longint'($signed(bmem[j])) * (longint'(1) << FRAC);
      for (int i = 0; i < ni; i++)
         acc += longint'($signed(xmem[i])) * longint'($signed(wmem[j*ni+i]));
      acc = (acc <<< (64-ACCW)) >>> (64-ACCW);
      q   = acc >>> FRAC;
      if (q > 32767)       q = 32767;
      else if (q < -32768) q = -32768;
      return DW'(q);
   endfunction

   function automatic logic [DW-1:0] rnd(input bit big);
      return big ? DW'($urandom) : DW'($urandom_range(0, 2047) - 1024);
   endfunction

   // Compare process: every write is matched in order against the model queue.
   always @(negedge clk) begin
      if (rst) begin
         if (busy) check("done_before_end", {63'd0, done}, 64'd0);
         if (y_we) begin
            n_writes++;
            ymem[y_wa[7:0]] = y_wd;
            if (exp_d.size() == 0) begin
               check("write_not_expected", {63'd0, y_we}, 64'd0);
            end else begin
               check("y_wa", {48'd0, y_wa}, {48'd0, exp_a.pop_front()});
               check("y_wd", {48'd0, y_wd}, {48'd0, exp_d.pop_front()});
            end
         end
      end
   end

   task automatic check_quiet(input string tag);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      check({tag, "_y_we"}, {63'd0, y_we}, 64'd0);
      check({tag, "_x_ra"}, {48'd0, x_ra}, 64'd0);
      check({tag, "_w_ra"}, {48'd0, w_ra}, 64'd0);
      check({tag, "_b_ra"}, {48'd0, b_ra}, 64'd0);
      check({tag, "_y_wa"}, {48'd0, y_wa}, 64'd0);
      check({tag, "_y_wd"}, {48'd0, y_wd}, 64'd0);
      check({tag, "_cls"},  {48'd0, cls},  64'd0);
   endtask

   task automatic load_expect(input int ni, input int no, output int best);
      logic [DW-1:0] y, besty;
      exp_d.delete();
      exp_a.delete();
      best  = 0;
      besty = '0;
      if (ni > 0) begin
         for (int j = 0; j < no; j++) begin
            y = model_y(ni, j);
            exp_d.push_back(y);
            exp_a.push_back(MW'(j));
            if (j == 0 || $signed(y) > $signed(besty)) begin
               besty = y;
               best  = j;
            end
         end
      end
   endtask

   task automatic fill_rand(input int ni, input int no, input bit big);
      for (int i = 0; i < ni; i++)    xmem[i] = rnd(big);
      for (int k = 0; k < ni*no; k++) wmem[k] = rnd(big);
      for (int j = 0; j < no; j++)    bmem[j] = rnd(big);
   endtask

   // One complete job: the sampling edge leaves IDLE, then NO*(NI+3) job
   // cycles; a zero-size job reaches DONE on the sampling edge itself.
   task automatic run_job(input int ni, input int no, input bit scramble);
      int best, cyc, exp_cyc, wr0;
      load_expect(ni, no, best);
      exp_cyc = (ni == 0 || no == 0) ? 1 : no*(ni+3) + 1;
      @(posedge clk); #1;
      NI   = DW'(ni);
      NO   = DW'(no);
      en   = 1'b1;
      busy = 1'b1;
      wr0  = n_writes;
      cyc  = 0;
      while (cyc < exp_cyc + 20) begin
         @(posedge clk); #1;
         cyc++;
         if (scramble && cyc == 2) begin
            NI = DW'($urandom);
            NO = DW'($urandom);
         end
         if (done) break;
      end
      busy = 1'b0;
      check("latency", 64'(cyc), 64'(exp_cyc));
      check("done", {63'd0, done}, 64'd1);
      check("write_count", 64'(n_writes - wr0), 64'((ni == 0) ? 0 : no));
      check("writes_pending", 64'(exp_d.size()), 64'd0);
`ifdef CNN_DENSE_ARGMAX_EN
      check("cls", {48'd0, cls}, 64'(best));
`else
      check("cls", {48'd0, cls}, 64'd0);
`endif
      @(posedge clk); #1;
      check("done_held", {63'd0, done}, 64'd1);
      en = 1'b0;
      @(posedge clk); #1;
      check("done_after_en_low", {63'd0, done}, 64'd0);
   endtask

   initial begin
      int wr0, nn, mm;
      for (int i = 0; i < 256; i++) begin
         xmem[i] = '0; wmem[i] = '0; bmem[i] = '0; ymem[i] = '0;
      end
      #3 check_quiet("reset");
      #19 rst = 1'b1;

      // Hand-computed job: y = {2.0, -1.25}.
      xmem[0] = 16'h0100; xmem[1] = 16'h0200; xmem[2] = 16'hFF00;
      wmem[0] = 16'h0100; wmem[1] = 16'h0100; wmem[2] = 16'h0100;
      wmem[3] = 16'h0080; wmem[4] = 16'h0000; wmem[5] = 16'h0200;
      bmem[0] = 16'h0000; bmem[1] = 16'h0040;
      run_job(3, 2, 1'b0);
      check("t1_y0", {48'd0, ymem[0]}, 64'h0200);
      check("t1_y1", {48'd0, ymem[1]}, 64'hFEC0);

      // Saturation both ways.
      xmem[0] = 16'h7F00; wmem[0] = 16'h7F00; bmem[0] = 16'h0000;
      run_job(1, 1, 1'b0);
      check("t2_pos_sat", {48'd0, ymem[0]}, 64'h7FFF);
      xmem[0] = 16'h8100;
      run_job(1, 1, 1'b0);
      check("t2_neg_sat", {48'd0, ymem[0]}, 64'h8000);

      // Zero-size job: no writes, done after one cycle.
      run_job(0, 4, 1'b0);

      // Tie on the maximum keeps the lowest index.
      xmem[0] = 16'h0100;
      wmem[0] = 16'h0500; wmem[1] = 16'h0900; wmem[2] = 16'h0900;
      bmem[0] = '0; bmem[1] = '0; bmem[2] = '0;
      run_job(1, 3, 1'b0);
      check("t4_y2", {48'd0, ymem[2]}, 64'h0900);
`ifdef CNN_DENSE_ARGMAX_EN
      check("t4_cls", {48'd0, cls}, 64'd1);
`else
      check("t4_cls", {48'd0, cls}, 64'd0);
`endif

      // Abort in the MAC phase of the second output.
      fill_rand(4, 3, 1'b0);
      load_expect(4, 3, nn);
      @(posedge clk); #1;
      NI = 16'd4; NO = 16'd3; en = 1'b1; busy = 1'b1; wr0 = n_writes;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (n_writes - wr0 >= 1) break;
      end
      check("abort_first_write", 64'(n_writes - wr0), 64'd1);
      @(posedge clk); #1;
      en = 1'b0; busy = 1'b0;
      exp_d.delete(); exp_a.delete();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("abort_no_done", {63'd0, done}, 64'd0);
      end
      check("abort_writes", 64'(n_writes - wr0), 64'd1);
      run_job(4, 3, 1'b0);

      // Asynchronous reset in the middle of a MAC phase.
      fill_rand(6, 2, 1'b0);
      @(posedge clk); #1;
      NI = 16'd6; NO = 16'd2; en = 1'b1;
      repeat (4) @(posedge clk);
      #3 rst = 1'b0;
      exp_d.delete(); exp_a.delete();
      #1 check_quiet("midjob_reset");
      en = 1'b0;
      #3 rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("post_reset_idle_done", {63'd0, done}, 64'd0);
         check("post_reset_idle_x_ra", {48'd0, x_ra}, 64'd0);
      end
      run_job(6, 2, 1'b0);

      // Randomized jobs, NI/NO inputs disturbed while running.
      for (int k = 0; k < 25; k++) begin
         nn = $urandom_range(0, 6);
         mm = $urandom_range(0, 5);
         fill_rand(nn, mm, ($urandom_range(0, 3) == 0));
         run_job(nn, mm, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
